// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the posted-write store buffer.
// A buffered store is kept as a word address plus its data word.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int WADDR_W  = 30;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [31:0]        data;
    } sb_entry_t;

    // Word address of a byte address (the byte offset is dropped)
    function automatic logic [WADDR_W-1:0] word_addr(input logic [31:0] byte_addr);
        return WADDR_W'(byte_addr >> 2);
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side request/response signals and the DataMemory port of the store buffer.
// The master drives the MEM-stage requests and supplies memory read data.
interface store_buffer_if;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        drain_req;
    logic [31:0] read_data;
    logic        stall;
    logic        empty;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output MemRead, MemWrite, address, write_data, drain_req, mem_read_data,
        input  read_data, stall, empty, mem_MemRead, mem_MemWrite, mem_address, mem_write_data
    );

    modport slave (
        input  MemRead, MemWrite, address, write_data, drain_req, mem_read_data,
        output read_data, stall, empty, mem_MemRead, mem_MemWrite, mem_address, mem_write_data
    );

endinterface

// File: rtl/store_buffer_match.sv
// Youngest-first address search over the valid entries of the store FIFO.
// Entries are scanned oldest to youngest so the last match found wins.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = 2
) (
    input  sb_entry_t          entries [DEPTH],
    input  logic [PTR_W-1:0]   head,
    input  logic [PTR_W:0]     count,
    input  logic [WADDR_W-1:0] waddr,
    output logic               hit,
    output logic [31:0]        data
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx_s;

    // Scan by age offset from head; only offsets below count hold live stores
    always_comb begin
        hit   = 1'b0;
        data  = 32'd0;
        idx_s = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx_s].waddr == waddr)) begin
                hit  = 1'b1;
                data = entries[idx_s].data;
            end else begin
                hit  = hit;
                data = data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and DataMemory: queues stores,
// forwards them to loads and retires one entry per cycle when the port is free.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  bus
);

    localparam int CNT_W = PTR_W + 1;

    sb_entry_t          entries_r [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;

    logic [WADDR_W-1:0] req_waddr_s;
    logic               load_s;
    logic               nonempty_s;
    logic               full_s;
    logic               hit_s;
    logic [31:0]        hit_data_s;
    logic               load_miss_s;
    logic               miss_hold_s;
    logic               enq_s;
    logic               drain_s;

    store_buffer_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .entries (entries_r),
        .head    (head_r),
        .count   (count_r),
        .waddr   (req_waddr_s),
        .hit     (hit_s),
        .data    (hit_data_s)
    );

    // Request decode, stall and drain arbitration for the shared memory port.
    // A store with MemRead also high is handled as a plain store.
    // Draining is suppressed during reset so discarded stores never reach memory.
    always_comb begin
        req_waddr_s = word_addr(bus.address);
        load_s      = bus.MemRead & ~bus.MemWrite;
        nonempty_s  = (count_r != {CNT_W{1'b0}});
        full_s      = (count_r == CNT_W'(DEPTH));
        load_miss_s = load_s & ~hit_s;
        miss_hold_s = load_miss_s & bus.drain_req & nonempty_s;
        enq_s       = bus.MemWrite & ~full_s;
        drain_s     = nonempty_s & (~load_miss_s | bus.drain_req) & ~reset;

        bus.stall        = (bus.MemWrite & full_s) | miss_hold_s;
        bus.empty        = ~nonempty_s;
        bus.mem_MemRead  = load_miss_s & ~miss_hold_s;
        bus.mem_MemWrite = drain_s;

        if (drain_s) begin
            bus.mem_address    = {entries_r[head_r].waddr, 2'b00};
            bus.mem_write_data = entries_r[head_r].data;
        end else if (bus.mem_MemRead) begin
            bus.mem_address    = bus.address;
            bus.mem_write_data = 32'd0;
        end else begin
            bus.mem_address    = 32'd0;
            bus.mem_write_data = 32'd0;
        end

        if (!load_s) begin
            bus.read_data = 32'd0;
        end else if (hit_s) begin
            bus.read_data = hit_data_s;
        end else if (bus.mem_MemRead) begin
            bus.read_data = bus.mem_read_data;
        end else begin
            bus.read_data = 32'd0;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (enq_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (drain_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(enq_s) - CNT_W'(drain_s);
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (enq_s && !reset) begin
            entries_r[tail_r] <= {req_waddr_s, bus.write_data};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, a short hand
// sequence and randomized traffic checked against a queue-based model.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = SB_DEPTH;

    logic clk;
    logic reset;
    store_buffer_if sbif ();

    store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMemory stand-in: combinational read, write on the rising edge
    logic [31:0] dmem [0:255];
    assign sbif.mem_read_data = dmem[sbif.mem_address[9:2]];
    always @(posedge clk) begin
        if (sbif.mem_MemWrite) dmem[sbif.mem_address[9:2]] <= sbif.mem_write_data;
    end

    // Reference model: pending stores in arrival order plus its own memory image
    typedef struct packed { logic [29:0] w; logic [31:0] d; } ment_t;
    ment_t       q [$];
    logic [31:0] ref_mem [0:255];

    logic        m_stall, m_mrd, m_mwr, m_empty, m_accept;
    logic [31:0] m_maddr, m_mwd, m_rdata;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic drn, input logic rst);
        sbif.MemRead    = rd;
        sbif.MemWrite   = wr;
        sbif.address    = addr;
        sbif.write_data = wd;
        sbif.drain_req  = drn;
        reset           = rst;
    endtask

    task automatic model_eval(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic drn, input logic rst);
        int   n;
        logic rde, hit, miss, busy;
        logic [31:0] hd;
        n    = q.size();
        rde  = rd & ~wr;
        hit  = 1'b0;
        hd   = 32'd0;
        if (rde) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (q[i].w == addr[31:2]) begin
                    hit = 1'b1;
                    hd  = q[i].d;
                    break;
                end
            end
        end
        miss     = rde & ~hit;
        busy     = drn && (n > 0);
        m_stall  = (wr && (n == DEPTH)) || (miss && busy);
        m_mrd    = miss && !busy;
        m_mwr    = (n > 0) && (!miss || drn) && !rst;
        m_maddr  = m_mwr ? {q[0].w, 2'b00} : addr;
        m_mwd    = m_mwr ? q[0].d : 32'd0;
        m_rdata  = !rde ? 32'd0 : hit ? hd : m_mrd ? ref_mem[addr[9:2]] : 32'd0;
        m_empty  = (n == 0);
        m_accept = wr && (n < DEPTH);
    endtask

    task automatic model_commit(input logic [31:0] addr, input logic [31:0] wd, input logic rst);
        if (rst) begin
            q.delete();
        end else begin
            if (m_mwr) begin
                ref_mem[q[0].w[7:0]] = q[0].d;
                void'(q.pop_front());
            end
            if (m_accept) q.push_back({addr[31:2], wd});
        end
    endtask

    // One cycle checked against the reference model
    task automatic model_cycle(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wd, input logic drn, input logic rst);
        drive(rd, wr, addr, wd, drn, rst);
        @(negedge clk);
        model_eval(rd, wr, addr, drn, rst);
        chk("stall", {31'd0, sbif.stall}, {31'd0, m_stall});
        chk("mem_MemRead", {31'd0, sbif.mem_MemRead}, {31'd0, m_mrd});
        chk("mem_MemWrite", {31'd0, sbif.mem_MemWrite}, {31'd0, m_mwr});
        chk("empty", {31'd0, sbif.empty}, {31'd0, m_empty});
        if (m_mrd || m_mwr) chk("mem_address", sbif.mem_address, m_maddr);
        if (m_mwr) chk("mem_write_data", sbif.mem_write_data, m_mwd);
        if (!m_stall) chk("read_data", sbif.read_data, m_rdata);
        model_commit(addr, wd, rst);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic [3:0]  ctl;   // {rd, wr, drain_req, reset}
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  ex;    // {stall, mem_MemRead, mem_MemWrite}
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [31:0] rdata;
        logic        empty;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [2:0] ex, input logic [31:0] maddr, input logic [31:0] mwd,
                                input logic [31:0] rdata, input logic empty);
        vec_t v;
        v.ctl = ctl; v.addr = addr; v.wd = wd; v.ex = ex;
        v.maddr = maddr; v.mwd = mwd; v.rdata = rdata; v.empty = empty;
        return v;
    endfunction

    vec_t vt [20];

    initial begin
        // Directed vectors, one per cycle, starting from reset; memory word i holds D0000000+i
        vt[0]  = mk(4'b0000, 32'h0,   32'h0,        3'b000, 32'h0,   32'h0,        32'h0,        1'b1);
        vt[1]  = mk(4'b0100, 32'h04,  32'h11111111, 3'b000, 32'h0,   32'h0,        32'h0,        1'b1);
        vt[2]  = mk(4'b0000, 32'h0,   32'h0,        3'b001, 32'h04,  32'h11111111, 32'h0,        1'b0);
        vt[3]  = mk(4'b1000, 32'h04,  32'h0,        3'b010, 32'h04,  32'h0,        32'h11111111, 1'b1);
        vt[4]  = mk(4'b0100, 32'h08,  32'hAAAAAAAA, 3'b000, 32'h0,   32'h0,        32'h0,        1'b1);
        vt[5]  = mk(4'b0100, 32'h08,  32'hBBBBBBBB, 3'b001, 32'h08,  32'hAAAAAAAA, 32'h0,        1'b0);
        vt[6]  = mk(4'b1000, 32'h08,  32'h0,        3'b001, 32'h08,  32'hBBBBBBBB, 32'hBBBBBBBB, 1'b0);
        vt[7]  = mk(4'b1000, 32'h08,  32'h0,        3'b010, 32'h08,  32'h0,        32'hBBBBBBBB, 1'b1);
        vt[8]  = mk(4'b0100, 32'h20,  32'h22222222, 3'b000, 32'h0,   32'h0,        32'h0,        1'b1);
        vt[9]  = mk(4'b1000, 32'h100, 32'h0,        3'b010, 32'h100, 32'h0,        32'hD0000040, 1'b0);
        vt[10] = mk(4'b1000, 32'h100, 32'h0,        3'b010, 32'h100, 32'h0,        32'hD0000040, 1'b0);
        vt[11] = mk(4'b1000, 32'h22,  32'h0,        3'b001, 32'h20,  32'h22222222, 32'h22222222, 1'b0);
        vt[12] = mk(4'b0100, 32'h40,  32'h33333333, 3'b000, 32'h0,   32'h0,        32'h0,        1'b1);
        vt[13] = mk(4'b1010, 32'h100, 32'h0,        3'b101, 32'h40,  32'h33333333, 32'h0,        1'b0);
        vt[14] = mk(4'b1010, 32'h100, 32'h0,        3'b010, 32'h100, 32'h0,        32'hD0000040, 1'b1);
        vt[15] = mk(4'b0100, 32'h40,  32'h44444444, 3'b000, 32'h0,   32'h0,        32'h0,        1'b1);
        vt[16] = mk(4'b0001, 32'h0,   32'h0,        3'b000, 32'h0,   32'h0,        32'h0,        1'b0);
        vt[17] = mk(4'b1000, 32'h40,  32'h0,        3'b010, 32'h40,  32'h0,        32'h33333333, 1'b1);
        vt[18] = mk(4'b1100, 32'h08,  32'h55555555, 3'b000, 32'h0,   32'h0,        32'h0,        1'b1);
        vt[19] = mk(4'b0000, 32'h0,   32'h0,        3'b001, 32'h08,  32'h55555555, 32'h0,        1'b0);

        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 32'hD000_0000 + 32'(i);
            ref_mem[i] = 32'hD000_0000 + 32'(i);
        end

        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].ctl[3], vt[i].ctl[2], vt[i].addr, vt[i].wd, vt[i].ctl[1], vt[i].ctl[0]);
            @(negedge clk);
            chk($sformatf("v%0d.stall", i), {31'd0, sbif.stall}, {31'd0, vt[i].ex[2]});
            chk($sformatf("v%0d.mem_MemRead", i), {31'd0, sbif.mem_MemRead}, {31'd0, vt[i].ex[1]});
            chk($sformatf("v%0d.mem_MemWrite", i), {31'd0, sbif.mem_MemWrite}, {31'd0, vt[i].ex[0]});
            chk($sformatf("v%0d.empty", i), {31'd0, sbif.empty}, {31'd0, vt[i].empty});
            if (vt[i].ex[1] || vt[i].ex[0]) chk($sformatf("v%0d.mem_address", i), sbif.mem_address, vt[i].maddr);
            if (vt[i].ex[0]) chk($sformatf("v%0d.mem_write_data", i), sbif.mem_write_data, vt[i].mwd);
            if (!vt[i].ex[2]) chk($sformatf("v%0d.read_data", i), sbif.read_data, vt[i].rdata);
            model_eval(vt[i].ctl[3], vt[i].ctl[2], vt[i].addr, vt[i].ctl[1], vt[i].ctl[0]);
            model_commit(vt[i].addr, vt[i].wd, vt[i].ctl[0]);
            @(posedge clk);
            #1;
            cyc++;
        end

        // Hand sequence: store visible to the very next load, idle drain_req on empty buffer
        model_cycle(1'b0, 1'b1, 32'h30, 32'h66666666, 1'b0, 1'b0);
        model_cycle(1'b1, 1'b0, 32'h31, 32'h0,        1'b0, 1'b0);
        model_cycle(1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0);
        model_cycle(1'b0, 1'b1, 32'h34, 32'h77777777, 1'b1, 1'b0);
        model_cycle(1'b1, 1'b0, 32'h34, 32'h0,        1'b1, 1'b0);
        model_cycle(1'b1, 1'b0, 32'h34, 32'h0,        1'b0, 1'b0);

        // Randomized traffic on a small address window so forwarding hits occur
        for (int k = 0; k < 1500; k++) begin
            logic        rd, wr, drn, rst;
            logic [31:0] addr, wd;
            rd   = ($urandom_range(0, 1) == 0);
            wr   = ($urandom_range(0, 9) < 3);
            drn  = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            addr = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            wd   = $urandom;
            model_cycle(rd, wr, addr, wd, drn, rst);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Word-granular posted-write buffer between the MEM pipeline stage and the DataMemory block.
- Stores from the pipeline are queued and retire to DataMemory one per cycle whenever the memory port is free, so the MEM stage does not wait on memory writes.
- Loads are checked against the pending stores; the youngest matching entry is forwarded, otherwise the load passes through to DataMemory.
- Stalls the pipeline only when the buffer is full, or when a load misses while a drain is being forced.

Parameters:
- DEPTH, 4, number of store entries (power of two, 2..16).
- PTR_W, 2, log2(DEPTH); sizes the head, tail and count registers.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  pipeline load request this cycle.
- MemWrite  in  1  pipeline store request this cycle.
- address  in  32  pipeline byte address; only [31:2] is used.
- write_data  in  32  store data.
- drain_req  in  1  force drain (fence/halt); draining takes priority over load misses.
- read_data  out  32  load result; combinational.
- stall  out  1  pipeline must hold MEM-stage inputs this cycle.
- empty  out  1  no pending stores.
- mem_MemRead  out  1  to DataMemory MemRead.
- mem_MemWrite  out  1  to DataMemory MemWrite.
- mem_address  out  32  to DataMemory address.
- mem_write_data  out  32  to DataMemory write_data.
- mem_read_data  in  32  from DataMemory read_data; combinational read.

Behaviour:
- Storage and reset:
  - Circular FIFO of DEPTH entries {waddr[29:0], data[31:0]}, with head/tail/count registers.
  - Reset: head = tail = count = 0. Entries are don't-care.
  - Reset mid-operation discards all pending stores. They are never written to memory.
- Output values:
  - After reset: empty = 1, stall = 0, mem_MemWrite = 0, mem_MemRead = 0.
  - read_data is 0 whenever MemRead = 0.
- MemRead and MemWrite both high is illegal; it is treated as a store only and read_data = 0.
- Store:
  - stall = MemWrite & (count == DEPTH). When stalled, nothing is enqueued.
  - Otherwise the entry {address[31:2], write_data} is written at tail on the rising edge; tail++ (wraps modulo DEPTH).
  - No coalescing: a repeated address appends a new entry.
  - Minimum latency from store to memory write is 1 cycle (the entry is drained at the earliest in the next cycle).
- Load:
  - Compare address[31:2] against all valid entries and select the youngest match (nearest to tail).
  - Hit: read_data = entry data in the same cycle; no memory read; stall = 0.
  - Miss with drain_req = 0: mem_MemRead = 1, mem_address = address, read_data = mem_read_data, stall = 0.
  - Miss with drain_req = 1 and count > 0: stall = 1 and mem_MemRead = 0. The load retries once the buffer is empty.
- Drain:
  - A drain occurs when count > 0 and the memory port is free. The port is free when there is no load miss this cycle, or when drain_req = 1.
  - On a drain: mem_MemWrite = 1, mem_address = {head.waddr, 2'b00}, mem_write_data = head.data. DataMemory writes on the same edge; head++ (wraps).
  - mem_MemRead and mem_MemWrite are never both 1.
- Counting:
  - An enqueue and a drain in the same cycle leave count unchanged.
  - Stall on full is based on count at the start of the cycle. A drain in that cycle does not admit the store; it is accepted next cycle.
  - Forwarding sees only entries present at the start of the cycle. A store accepted this cycle is visible to a load next cycle.
  - An entry draining this cycle is still a valid forwarding source during that cycle.
- empty = (count == 0).
- All mem_* outputs are combinational from state and inputs. No extra pipeline register.

Decomposition:
- Shared package store_buffer_pkg:
  - SB_DEPTH default.
  - WADDR_W = 30.
  - Entry struct type {waddr, data}.
  - Function to convert a byte address to a word address.
- One sub-module: store_buffer_match. Combinational youngest-first search over valid entries given head and count; outputs hit and data.

Test Plan:
- Reset, then a store to 0x04 = 0x11111111 with no loads → mem_MemWrite = 1, mem_address = 0x04 in the next cycle; empty = 1 afterwards; a load from 0x04 then misses and returns 0x11111111 via memory.
- Two stores to 0x08 (0xAAAAAAAA, then 0xBBBBBBBB), followed immediately by a load from 0x08 with drain held off by back-to-back misses → read_data = 0xBBBBBBBB forwarded and mem_MemRead = 0.
- 5 back-to-back stores with DEPTH = 4 and continuous load misses on 0x100 → stall = 1 on the 5th store. Releasing the loads lets the head drain; the 5th store is accepted the following cycle; memory sees addresses in FIFO order.
- Load miss on 0x20 while count = 2 → mem_MemRead = 1, mem_MemWrite = 0, read_data = memory word, count stays 2; next idle cycle drains.
- drain_req = 1 with count = 3 and a load miss on 0x40 → stall = 1 for 3 cycles, three writes retire, then the load completes with stall = 0.
- Reset asserted with count = 3 → no further mem_MemWrite and empty = 1 after the edge; a subsequent load of a previously buffered address returns the memory value, not the discarded data.
